// File: rtl/dp_csr_pkg.sv
// rtl/dp_csr_pkg.sv - shared types, codes and helpers for the AXI-Lite CSR block
package dp_csr_pkg;

  localparam int DW = 32;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam int IDX_ID       = 0;
  localparam int IDX_CTRL     = 1;
  localparam int IDX_STATUS   = 2;
  localparam int IDX_SCRATCH0 = 3;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  function automatic logic [DW-1:0] apply_wstrb(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [DW/8-1:0] strb);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < DW/8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_axil_csr_if.sv
// rtl/dp_axil_csr_if.sv - AXI4-Lite bus bundle between agent (master) and CSR block (slave)
interface dp_axil_csr_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/dp_csr_regfile.sv
// rtl/dp_csr_regfile.sv - word register storage with strobe merge and RO/unmapped decode
module dp_csr_regfile
  import dp_csr_pkg::*;
#(
  parameter int          IW         = 10,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] ID_VALUE   = 32'h00D0_0001,
  parameter logic [31:0] CTRL_RESET = 32'h0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_strb,
  output logic [1:0]      wr_resp,
  input  logic [IW-1:0]   rd_idx,
  output logic [DW-1:0]   rd_data,
  output logic [1:0]      rd_resp,
  input  logic [DW-1:0]   status_i,
  output logic [DW-1:0]   ctrl_o
);

  localparam int NS = NUM_REGS - IDX_SCRATCH0;

  logic [DW-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0] scratch_q [NS];
  logic [DW-1:0] scratch_d [NS];
  int            wr_i;
  int            rd_i;

  assign wr_i   = 32'(wr_idx);
  assign rd_i   = 32'(rd_idx);
  assign ctrl_o = ctrl_q;

  always_comb begin
    wr_resp = RESP_OKAY;
    if (wr_i >= NUM_REGS) begin
      wr_resp = RESP_DECERR;
    end else if (wr_i == IDX_ID || wr_i == IDX_STATUS) begin
      wr_resp = RESP_SLVERR;
    end
  end

  // Only OKAY-decoded writes reach storage; error responses leave state untouched.
  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    if (wr_en && wr_resp == RESP_OKAY) begin
      if (wr_i == IDX_CTRL) ctrl_d = apply_wstrb(ctrl_q, wr_data, wr_strb);
      for (int k = 0; k < NS; k++) begin
        if (wr_i == IDX_SCRATCH0 + k) scratch_d[k] = apply_wstrb(scratch_q[k], wr_data, wr_strb);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (rd_i >= NUM_REGS) begin
      rd_resp = RESP_DECERR;
    end else if (rd_i == IDX_ID) begin
      rd_data = ID_VALUE;
    end else if (rd_i == IDX_CTRL) begin
      rd_data = ctrl_q;
    end else if (rd_i == IDX_STATUS) begin
      rd_data = status_i;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (rd_i == IDX_SCRATCH0 + k) rd_data = scratch_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= CTRL_RESET;
      for (int k = 0; k < NS; k++) scratch_q[k] <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
    end
  end

endmodule

// File: rtl/dp_axil_csr.sv
// rtl/dp_axil_csr.sv - AXI4-Lite slave handshake FSMs in front of the CSR register file
module dp_axil_csr
  import dp_csr_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] ID_VALUE   = 32'h00D0_0001,
  parameter logic [31:0] CTRL_RESET = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dp_axil_csr_if.slave          axil,
  input  logic [DATA_WIDTH-1:0] status_i,
  output logic [DATA_WIDTH-1:0] ctrl_o
);

  localparam int IW = ADDR_WIDTH - 2;

  logic                    live_q, live_d;
  wr_state_t               wr_state_q, wr_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [IW-1:0]           awidx_q, awidx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  rd_state_t               rd_state_q, rd_state_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic                    aw_hs, w_hs, ar_hs;
  logic                    wr_en;
  logic [1:0]              wr_resp;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [1:0]              rd_resp;
  logic                    unused_addr_lsbs;

  assign unused_addr_lsbs = ^{axil.awaddr[1:0], axil.araddr[1:0]};

  // live_q keeps all readies low until the first edge after reset release.
  assign axil.awready = live_q && !aw_held_q && !bvalid_q;
  assign axil.wready  = live_q && !w_held_q && !bvalid_q;
  assign axil.arready = live_q && !rvalid_q;
  assign axil.bvalid  = bvalid_q;
  assign axil.bresp   = bresp_q;
  assign axil.rvalid  = rvalid_q;
  assign axil.rdata   = rdata_q;
  assign axil.rresp   = rresp_q;

  assign aw_hs = axil.awvalid && axil.awready;
  assign w_hs  = axil.wvalid && axil.wready;
  assign ar_hs = axil.arvalid && axil.arready;

  dp_csr_regfile #(
    .IW         (IW),
    .NUM_REGS   (NUM_REGS),
    .ID_VALUE   (ID_VALUE),
    .CTRL_RESET (CTRL_RESET)
  ) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_idx   (awidx_q),
    .wr_data  (wdata_q),
    .wr_strb  (wstrb_q),
    .wr_resp  (wr_resp),
    .rd_idx   (axil.araddr[ADDR_WIDTH-1:2]),
    .rd_data  (rd_data),
    .rd_resp  (rd_resp),
    .status_i (status_i),
    .ctrl_o   (ctrl_o)
  );

  always_comb begin
    live_d     = 1'b1;
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awidx_d    = awidx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_en      = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = axil.awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = axil.wdata;
          wstrb_d  = axil.wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) wr_state_d = WR_COMMIT;
      end
      WR_COMMIT: begin
        wr_en      = 1'b1;
        bvalid_d   = 1'b1;
        bresp_d    = wr_resp;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        if (axil.bready) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read data is captured from the pre-commit storage, so a same-edge write is not visible.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rvalid_d   = 1'b1;
          rdata_d    = rd_data;
          rresp_d    = rd_resp;
          rd_state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (axil.rready) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q     <= 1'b0;
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      live_q     <= live_d;
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_dp_axil_csr.sv
// tb/tb_dp_axil_csr.sv - directed self-checking bench for the AXI-Lite CSR block
module tb_dp_axil_csr;

  logic        clk;
  logic        reset_n;
  logic [31:0] status;
  logic [31:0] ctrl;
  int          vectors;
  int          errs;

  dp_axil_csr_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) axil ();

  dp_axil_csr #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .NUM_REGS   (8),
    .ID_VALUE   (32'h00D0_0001),
    .CTRL_RESET (32'h0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .axil     (axil),
    .status_i (status),
    .ctrl_o   (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    int   n;
    logic aw_go, w_go;
    axil.awvalid = 1'b1; axil.awaddr = a;
    axil.wvalid  = 1'b1; axil.wdata  = d; axil.wstrb = s;
    axil.bready  = 1'b1;
    n = 0;
    while ((axil.awvalid || axil.wvalid) && n < 20) begin
      aw_go = axil.awvalid && axil.awready;
      w_go  = axil.wvalid && axil.wready;
      @(negedge clk);
      if (aw_go) axil.awvalid = 1'b0;
      if (w_go)  axil.wvalid  = 1'b0;
      n++;
    end
    lat = 0;
    while (!axil.bvalid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("wr_no_timeout", 32'(n < 20 && lat < 20), 32'd1);
    resp = axil.bresp;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int   n;
    logic go;
    axil.arvalid = 1'b1; axil.araddr = a; axil.rready = 1'b1;
    n = 0;
    while (axil.arvalid && n < 20) begin
      go = axil.arready;
      @(negedge clk);
      if (go) axil.arvalid = 1'b0;
      n++;
    end
    while (!axil.rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rd_no_timeout", 32'(n < 40), 32'd1);
    d    = axil.rdata;
    resp = axil.rresp;
    axil.arvalid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          lat;
    vectors = 0;
    errs    = 0;
    reset_n = 1'b0;
    status  = 32'h0;
    axil.awvalid = 1'b0; axil.awaddr = '0;
    axil.wvalid  = 1'b0; axil.wdata  = '0; axil.wstrb = '0;
    axil.bready  = 1'b0;
    axil.arvalid = 1'b0; axil.araddr = '0; axil.rready = 1'b0;

    // 1. Reset and first cycle after release
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(axil.awready), 32'd0);
    chk("rst_wready",  32'(axil.wready),  32'd0);
    chk("rst_arready", 32'(axil.arready), 32'd0);
    chk("rst_bvalid",  32'(axil.bvalid),  32'd0);
    chk("rst_rvalid",  32'(axil.rvalid),  32'd0);
    chk("rst_rdata",   axil.rdata,        32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 32'(axil.awready), 32'd1);
    chk("post_rst_wready",  32'(axil.wready),  32'd1);
    chk("post_rst_arready", 32'(axil.arready), 32'd1);
    axi_read(12'h000, rd, rsp);
    chk("id_data", rd, 32'h00D0_0001);
    chk("id_resp", 32'(rsp), 32'd0);
    axi_read(12'h004, rd, rsp);
    chk("ctrl_reset_data", rd, 32'h0);
    chk("ctrl_o_reset", ctrl, 32'h0);

    // 2. Strobed CTRL write: lanes 0 and 2 of A5A5_1234 land on a zero word
    axi_write(12'h004, 32'hA5A5_1234, 4'b0101, rsp, lat);
    chk("ctrl_wr_resp", 32'(rsp), 32'd0);
    chk("ctrl_wr_latency", 32'(lat), 32'd1);
    chk("ctrl_o_strobed", ctrl, 32'h00A5_0034);
    axi_read(12'h004, rd, rsp);
    chk("ctrl_readback", rd, 32'h00A5_0034);

    // 3. W three cycles ahead of AW, bready held low for five cycles
    axil.bready = 1'b0;
    axil.wvalid = 1'b1; axil.wdata = 32'h1; axil.wstrb = 4'hF;
    @(negedge clk);
    axil.wvalid = 1'b0;
    chk("w_held_wready", 32'(axil.wready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("w_only_no_bvalid", 32'(axil.bvalid), 32'd0);
    axil.awvalid = 1'b1; axil.awaddr = 12'h00C;
    chk("late_aw_awready", 32'(axil.awready), 32'd1);
    @(negedge clk);
    axil.awvalid = 1'b0;
    chk("commit_bvalid_low", 32'(axil.bvalid), 32'd0);
    @(negedge clk);
    chk("decoupled_bvalid", 32'(axil.bvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_bvalid",  32'(axil.bvalid),  32'd1);
      chk("stall_bresp",   32'(axil.bresp),   32'd0);
      chk("stall_awready", 32'(axil.awready), 32'd0);
      chk("stall_wready",  32'(axil.wready),  32'd0);
    end
    axil.bready = 1'b1;
    @(negedge clk);
    chk("b_hs_bvalid", 32'(axil.bvalid), 32'd0);
    chk("b_hs_awready", 32'(axil.awready), 32'd1);
    axi_read(12'h00C, rd, rsp);
    chk("scratch_value", rd, 32'h1);

    // 4. Error responses
    axi_write(12'h000, 32'hFFFF_FFFF, 4'hF, rsp, lat);
    chk("wr_id_slverr", 32'(rsp), 32'd2);
    axi_read(12'h000, rd, rsp);
    chk("id_unchanged", rd, 32'h00D0_0001);
    axi_write(12'h008, 32'h1234_5678, 4'hF, rsp, lat);
    chk("wr_status_slverr", 32'(rsp), 32'd2);
    axi_write(12'h020, 32'h1234_5678, 4'hF, rsp, lat);
    chk("wr_unmapped_decerr", 32'(rsp), 32'd3);
    axi_read(12'hFFC, rd, rsp);
    chk("rd_unmapped_data", rd, 32'h0);
    chk("rd_unmapped_decerr", 32'(rsp), 32'd3);

    // 5. Read capture on the same edge as the write commit
    axil.awvalid = 1'b1; axil.awaddr = 12'h00C;
    axil.wvalid  = 1'b1; axil.wdata  = 32'h2; axil.wstrb = 4'hF;
    axil.bready  = 1'b1;
    @(negedge clk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
    axil.arvalid = 1'b1; axil.araddr = 12'h00C; axil.rready = 1'b1;
    @(negedge clk);
    axil.arvalid = 1'b0;
    chk("race_rvalid", 32'(axil.rvalid), 32'd1);
    chk("race_old_value", axil.rdata, 32'h1);
    chk("race_bvalid", 32'(axil.bvalid), 32'd1);
    @(negedge clk);
    axi_read(12'h00C, rd, rsp);
    chk("race_new_value", rd, 32'h2);
    status = 32'hCAFE_F00D;
    axi_read(12'h008, rd, rsp);
    chk("status_data", rd, 32'hCAFE_F00D);
    chk("status_resp", 32'(rsp), 32'd0);

    // 6. Reset while both responses are pending
    axil.bready = 1'b0; axil.rready = 1'b0;
    axil.awvalid = 1'b1; axil.awaddr = 12'h010;
    axil.wvalid  = 1'b1; axil.wdata  = 32'h55; axil.wstrb = 4'hF;
    axil.arvalid = 1'b1; axil.araddr = 12'h010;
    @(negedge clk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_bvalid", 32'(axil.bvalid), 32'd1);
    chk("pre_rst_rvalid", 32'(axil.rvalid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_bvalid", 32'(axil.bvalid), 32'd0);
    chk("async_rst_rvalid", 32'(axil.rvalid), 32'd0);
    axil.bready = 1'b1; axil.rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_bvalid", 32'(axil.bvalid), 32'd0);
      chk("no_stale_rvalid", 32'(axil.rvalid), 32'd0);
    end
    axi_read(12'h010, rd, rsp);
    chk("scratch1_cleared", rd, 32'h0);
    axi_read(12'h00C, rd, rsp);
    chk("scratch0_cleared", rd, 32'h0);
    chk("ctrl_o_after_rst", ctrl, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
